// File: rtl/psram_burst_packer.sv
// psram_burst_packer: buffers an xClk-domain word stream in a FIFO and splits each
// transaction into PSRAM write bursts of at most MAX_BURST words that never cross
// a PAGE_WORDS page boundary.
// Ports:
//   xClk, xRstN           clock, async active-low reset
//   sStart, sAddr         transaction start pulse and start word address (IDLE only)
//   sValid/sData/sLast    input word stream, accepted when sValid && sReady
//   sReady                stream back-pressure
//   mRamReady             PSRAM controller can take a burst request
//   mReqWrite             one-cycle burst request pulse
//   mAddr, mLen           burst start address and length, held until the burst drains
//   mRdEn, mDout          controller pop strobe and first-word fall-through FIFO head
//   busy, done, err       not-idle flag, transaction-complete pulse, sticky pop error
module psram_burst_packer #(
    parameter int unsigned DW         = 16,
    parameter int unsigned AW         = 23,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned MAX_BURST  = 32,
    parameter int unsigned PAGE_WORDS = 1024,
    localparam int unsigned LW        = $clog2(MAX_BURST + 1)
) (
    input  logic          xClk,
    input  logic          xRstN,
    input  logic          sStart,
    input  logic [AW-1:0] sAddr,
    input  logic          sValid,
    input  logic [DW-1:0] sData,
    input  logic          sLast,
    output logic          sReady,
    input  logic          mRamReady,
    output logic          mReqWrite,
    output logic [AW-1:0] mAddr,
    output logic [LW-1:0] mLen,
    input  logic          mRdEn,
    output logic [DW-1:0] mDout,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = $clog2(DEPTH + 1);
    localparam int unsigned CMPW = (CNTW > LW) ? CNTW : LW;

    typedef enum logic [1:0] {IDLE, COLLECT, REQ, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cur_addr_q, cur_addr_d;
    logic            last_seen_q, last_seen_d;
    logic [AW-1:0]   m_addr_q, m_addr_d;
    logic [LW-1:0]   m_len_q, m_len_d;
    logic [LW-1:0]   word_cnt_q, word_cnt_d;
    logic            req_q, req_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [DW-1:0]   mem_q [DEPTH];
    logic [PTRW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0] count_q;

    logic            fifo_full_c, fifo_empty_c, s_ready_c, push_c, pop_c;
    logic [AW:0]     room_c;
    logic [LW-1:0]   chunk_c;
    logic            full_chunk_c, flush_c, burst_end_c;

    // FIFO status, handshakes and burst sizing
    always_comb begin
        fifo_full_c  = (count_q == CNTW'(DEPTH));
        fifo_empty_c = (count_q == '0);
        s_ready_c    = (state_q != IDLE) && !last_seen_q && !fifo_full_c;
        push_c       = sValid && s_ready_c;
        pop_c        = mRdEn && (state_q == DRAIN) && !fifo_empty_c;
        // words left before the next page boundary, then clipped to MAX_BURST
        room_c       = (AW+1)'(PAGE_WORDS) - {1'b0, cur_addr_q & AW'(PAGE_WORDS - 1)};
        chunk_c      = (room_c >= (AW+1)'(MAX_BURST)) ? LW'(MAX_BURST) : LW'(room_c);
        full_chunk_c = (CMPW'(count_q) >= CMPW'(chunk_c));
        // tail of a transaction: shorter burst once the last word is buffered
        flush_c      = last_seen_q && !fifo_empty_c;
        burst_end_c  = pop_c && ((word_cnt_q + LW'(1)) == m_len_q);
    end

    // State register
    always_ff @(posedge xClk or negedge xRstN) begin
        if (!xRstN) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sStart) state_d = COLLECT;
            COLLECT: begin
                if (full_chunk_c || flush_c)          state_d = REQ;
                else if (last_seen_q && fifo_empty_c) state_d = IDLE;
            end
            REQ:     if (mRamReady) state_d = DRAIN;
            DRAIN:   if (burst_end_c) state_d = COLLECT;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        cur_addr_d  = cur_addr_q;
        last_seen_d = last_seen_q | (push_c && sLast);
        m_addr_d    = m_addr_q;
        m_len_d     = m_len_q;
        word_cnt_d  = word_cnt_q;
        req_d       = 1'b0;
        done_d      = 1'b0;
        // popping outside DRAIN or from an empty FIFO is a controller protocol error
        err_d       = err_q | (mRdEn && ((state_q != DRAIN) || fifo_empty_c));
        case (state_q)
            IDLE: begin
                if (sStart) begin
                    cur_addr_d  = sAddr;
                    last_seen_d = 1'b0;
                end
            end
            COLLECT: begin
                if (full_chunk_c || flush_c) begin
                    m_addr_d = cur_addr_q;
                    m_len_d  = full_chunk_c ? chunk_c : LW'(count_q);
                end else if (last_seen_q && fifo_empty_c) begin
                    done_d = 1'b1;
                end
            end
            REQ:  req_d = mRamReady;
            DRAIN: begin
                if (pop_c) word_cnt_d = word_cnt_q + LW'(1);
                if (burst_end_c) begin
                    word_cnt_d = '0;
                    cur_addr_d = cur_addr_q + AW'(m_len_q);
                end
            end
            default: ;
        endcase
    end

    // Control and burst registers
    always_ff @(posedge xClk or negedge xRstN) begin
        if (!xRstN) begin
            cur_addr_q  <= '0;
            last_seen_q <= 1'b0;
            m_addr_q    <= '0;
            m_len_q     <= '0;
            word_cnt_q  <= '0;
            req_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cur_addr_q  <= cur_addr_d;
            last_seen_q <= last_seen_d;
            m_addr_q    <= m_addr_d;
            m_len_q     <= m_len_d;
            word_cnt_q  <= word_cnt_d;
            req_q       <= req_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Word FIFO; storage is cleared on reset so mDout reads 0 out of reset
    always_ff @(posedge xClk or negedge xRstN) begin
        if (!xRstN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            if (push_c) begin
                mem_q[wr_ptr_q] <= sData;
                wr_ptr_q        <= wr_ptr_q + PTRW'(1);
            end
            if (pop_c) rd_ptr_q <= rd_ptr_q + PTRW'(1);
            if (push_c && !pop_c)      count_q <= count_q + CNTW'(1);
            else if (pop_c && !push_c) count_q <= count_q - CNTW'(1);
        end
    end

    assign sReady    = s_ready_c;
    assign mReqWrite = req_q;
    assign mAddr     = m_addr_q;
    assign mLen      = m_len_q;
    assign mDout     = mem_q[rd_ptr_q];
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_psram_burst_packer.sv
// tb_psram_burst_packer: drives random transactions into psram_burst_packer while
// acting as the PSRAM controller, and checks bursts, data order, flags and reset
// against a greedy page/MAX_BURST split model.
module tb_psram_burst_packer;

    localparam int unsigned DW         = 16;
    localparam int unsigned AW         = 23;
    localparam int unsigned DEPTH      = 64;
    localparam int unsigned MAX_BURST  = 32;
    localparam int unsigned PAGE_WORDS = 1024;
    localparam int unsigned LW         = $clog2(MAX_BURST + 1);

    logic          xClk = 1'b0;
    logic          xRstN;
    logic          sStart;
    logic [AW-1:0] sAddr;
    logic          sValid;
    logic [DW-1:0] sData;
    logic          sLast;
    logic          sReady;
    logic          mRamReady;
    logic          mReqWrite;
    logic [AW-1:0] mAddr;
    logic [LW-1:0] mLen;
    logic          mRdEn;
    logic [DW-1:0] mDout;
    logic          busy;
    logic          done;
    logic          err;

    psram_burst_packer #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST), .PAGE_WORDS(PAGE_WORDS)
    ) dut (
        .xClk(xClk), .xRstN(xRstN), .sStart(sStart), .sAddr(sAddr),
        .sValid(sValid), .sData(sData), .sLast(sLast), .sReady(sReady),
        .mRamReady(mRamReady), .mReqWrite(mReqWrite), .mAddr(mAddr), .mLen(mLen),
        .mRdEn(mRdEn), .mDout(mDout), .busy(busy), .done(done), .err(err)
    );

    always #5 xClk = ~xClk;

    int checks = 0;
    int errors = 0;
    bit exp_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string ctx);
        chk({ctx, "_busy"},      32'(busy), 32'(0));
        chk({ctx, "_sready"},    32'(sReady), 32'(0));
        chk({ctx, "_mreqwrite"}, 32'(mReqWrite), 32'(0));
        chk({ctx, "_done"},      32'(done), 32'(0));
        chk({ctx, "_err"},       32'(err), 32'(0));
        chk({ctx, "_maddr"},     32'(mAddr), 32'(0));
        chk({ctx, "_mlen"},      32'(mLen), 32'(0));
    endtask

    // One transaction: random data, expected bursts from a greedy split, bench acts
    // as source and controller. abort_pops>0 returns mid-burst after that many pops.
    task automatic run_txn(input int addr, input int n, input int v_pct, input int r_pct,
                           input int rd_pct, input bit hold_full, input bit err_poke,
                           input int abort_pops);
        int data_q[$];
        int b_addr[$];
        int b_len[$];
        int a, r, room, c;
        int ip, ipop, bi, rem, held_a, held_l, done_cnt;
        bit last_pushed, released, finished;

        for (int i = 0; i < n; i++) data_q.push_back(int'($urandom_range(0, 65535)));
        a = addr;
        r = n;
        while (r > 0) begin
            room = int'(PAGE_WORDS) - (a % int'(PAGE_WORDS));
            c = int'(MAX_BURST);
            if (room < c) c = room;
            if (r < c) c = r;
            b_addr.push_back(a);
            b_len.push_back(c);
            a = (a + c) % (1 << AW);
            r -= c;
        end

        @(negedge xClk);
        sStart = 1'b1;
        sAddr  = AW'(addr);
        @(negedge xClk);
        sStart = 1'b0;

        ip = 0; ipop = 0; bi = 0; rem = 0; held_a = 0; held_l = 0; done_cnt = 0;
        last_pushed = 1'b0; released = 1'b0; finished = 1'b0;

        for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
            chk("err_flag", 32'(err), 32'(exp_err));
            if (mReqWrite) begin
                chk("req_while_draining", 32'(rem), 32'(0));
                if (bi < b_addr.size()) begin
                    chk("burst_addr", 32'(mAddr), 32'(b_addr[bi]));
                    chk("burst_len", 32'(mLen), 32'(b_len[bi]));
                    chk("page_cross", 32'((int'(mAddr) % int'(PAGE_WORDS)) + int'(mLen) <= int'(PAGE_WORDS)), 32'(1));
                    held_a = b_addr[bi];
                    held_l = b_len[bi];
                    rem    = b_len[bi];
                end else begin
                    chk("extra_burst", 32'(bi + 1), 32'(b_addr.size()));
                end
                bi++;
            end else if (rem > 0) begin
                chk("addr_held", 32'(mAddr), 32'(held_a));
                chk("len_held", 32'(mLen), 32'(held_l));
            end
            if (done) begin
                done_cnt++;
                finished = 1'b1;
                chk("busy_after_done", 32'(busy), 32'(0));
                chk("all_popped", 32'(ipop), 32'(n));
                chk("all_bursts", 32'(bi), 32'(b_addr.size()));
            end else begin
                if (last_pushed) chk("sready_after_last", 32'(sReady), 32'(0));
                if (hold_full && !released && !last_pushed && !sReady) begin
                    chk("fill_level", 32'(ip), 32'(DEPTH));
                    released = 1'b1;
                end
                if (abort_pops > 0 && ipop >= abort_pops) begin
                    chk("busy_mid_drain", 32'(busy), 32'(1));
                    sValid = 1'b0;
                    mRdEn  = 1'b0;
                    return;
                end
                sValid = (ip < n) && ($urandom_range(1, 100) <= v_pct);
                sData  = '0;
                if (ip < n) sData = DW'(data_q[ip]);
                sLast  = (ip == n - 1);
                if (sValid && sReady) begin
                    if (ip == n - 1) last_pushed = 1'b1;
                    ip++;
                end
                mRamReady = (hold_full && !released) ? 1'b0 : ($urandom_range(1, 100) <= r_pct);
                mRdEn = 1'b0;
                if (err_poke && cyc == 0) begin
                    mRdEn   = 1'b1;
                    exp_err = 1'b1;
                end else if (rem > 0 && $urandom_range(1, 100) <= rd_pct) begin
                    mRdEn = 1'b1;
                    chk("data", 32'(mDout), 32'(data_q[ipop]));
                    ipop++;
                    rem--;
                end
                @(negedge xClk);
            end
        end
        sValid    = 1'b0;
        sLast     = 1'b0;
        mRdEn     = 1'b0;
        mRamReady = 1'b0;
        if (!finished) begin
            chk("done_timeout", 32'(done_cnt), 32'(1));
        end else begin
            @(negedge xClk);
            chk("done_single_pulse", 32'(done), 32'(0));
            chk("idle_busy", 32'(busy), 32'(0));
        end
    endtask

    initial begin
        xRstN = 1'b1; sStart = 1'b0; sAddr = '0; sValid = 1'b0; sData = '0;
        sLast = 1'b0; mRamReady = 1'b0; mRdEn = 1'b0;
        #1 xRstN = 1'b0;
        #2 chk_reset_outputs("por");
        repeat (2) @(negedge xClk);
        xRstN = 1'b1;

        // two full 32-word bursts from address 0
        run_txn(0, 64, 100, 100, 100, 1'b0, 1'b0, 0);
        // page split at 0x400
        run_txn('h3F0, 40, 80, 100, 100, 1'b0, 1'b0, 0);
        // short transaction flushed on sLast
        run_txn('h1234, 5, 70, 100, 100, 1'b0, 1'b0, 0);
        // controller stalled until the FIFO fills
        run_txn('h200, 100, 100, 100, 60, 1'b1, 1'b0, 0);
        // address wrap at the top of the space
        run_txn('h7FFFF0, 40, 80, 60, 70, 1'b0, 1'b0, 0);
        // random transactions, half of them starting just before a page end
        for (int t = 0; t < 6; t++) begin
            int ra;
            if (t % 2 == 0) ra = int'($urandom_range(0, (1 << AW) - 1));
            else ra = int'($urandom_range(0, 8191)) * int'(PAGE_WORDS) - int'($urandom_range(1, 40));
            if (ra < 0) ra = ra + (1 << AW);
            run_txn(ra, int'($urandom_range(1, 90)), int'($urandom_range(30, 100)),
                    int'($urandom_range(20, 100)), int'($urandom_range(30, 100)), 1'b0, 1'b0, 0);
        end
        // pop while collecting with an empty FIFO, error stays set
        run_txn('h50, 20, 80, 80, 80, 1'b0, 1'b1, 0);
        chk("err_sticky", 32'(err), 32'(1));
        // reset in the middle of a burst drain
        run_txn('h3E0, 60, 100, 100, 50, 1'b0, 1'b0, 10);
        #2 xRstN = 1'b0;
        #1 chk_reset_outputs("mid_drain_rst");
        exp_err = 1'b0;
        @(negedge xClk);
        xRstN = 1'b1;
        run_txn('h3E0, 60, 90, 100, 80, 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
